// File: rtl/dmem_pkg.sv
// dmem_pkg: load/store funct3 codes, responder FSM states and the access fault check.
package dmem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    function automatic logic is_fault(input logic store, input logic [2:0] lt,
                                      input logic [2:0] st, input logic [1:0] a);
        logic [2:0] f;
        f = store ? st : lt;
        if (store && st > F3_W) return 1'b1;
        if (!store && !(lt inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})) return 1'b1;
        // low two funct3 bits give the access size for both loads and stores
        return (f[1:0] == 2'b01 && a[0]) || (f[1:0] == 2'b10 && a != 2'b00);
    endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane extraction/extension for loads, byte enables and data replication for stores.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [2:0]  load_type,
    input  logic [2:0]  store_type,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data,
    output logic [3:0]  byte_en
);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        sh = word >> {lane, 3'b000};
        b = sh[7:0];
        h = lane[1] ? word[31:16] : word[15:0];
        load_data = load_type == F3_B  ? {{24{b[7]}}, b} :
                    load_type == F3_H  ? {{16{h[15]}}, h} :
                    load_type == F3_W  ? word :
                    load_type == F3_BU ? {24'd0, b} :
                    load_type == F3_HU ? {16'd0, h} : 32'd0;
        byte_en = store_type == F3_B ? 4'b0001 << lane :
                  store_type == F3_H ? (lane[1] ? 4'b1100 : 4'b0011) :
                  store_type == F3_W ? 4'b1111 : 4'b0000;
        store_data = store_type == F3_B ? {4{wdata[7:0]}} :
                     store_type == F3_H ? {2{wdata[15:0]}} : wdata;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency load/store responder on a word RAM with busy/valid handshake.
// DMEM_WRITE_ACK_EN: when defined, stores run the full FSM; otherwise clean stores write at acceptance.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [2:0]  load_type,
    input  logic [2:0]  store_type,
    input  logic [31:0] ram_address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        mem_busy,
    output logic        mem_valid,
    output logic        access_fault
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [31:0] addr_l, wdata_l, cur_addr, cur_wdata, load_data, store_data;
    logic [2:0] lt_l, st_l, cur_lt, cur_st;
    logic store_l, idle, cur_store, cur_fault, go, enter_resp, ram_we;
    logic [3:0] byte_en;
    logic [AW-1:0] idx;
    logic unused_addr;
    logic [31:0] ram [DEPTH_WORDS];

    // in IDLE the live request is decoded; once accepted the latched copy drives everything
    always_comb begin
        idle = state == IDLE;
        cur_store = idle ? mem_write_en : store_l;
        cur_addr = idle ? ram_address : addr_l;
        cur_wdata = idle ? data_in : wdata_l;
        cur_lt = idle ? load_type : lt_l;
        cur_st = idle ? store_type : st_l;
        cur_fault = is_fault(cur_store, cur_lt, cur_st, cur_addr[1:0]);
        idx = cur_addr[AW+1:2];
`ifdef DMEM_WRITE_ACK_EN
        go = idle && (mem_read_en || mem_write_en);
`else
        go = idle && (mem_write_en ? cur_fault : mem_read_en);
`endif
        state_nx = state;
        cnt_nx = cnt;
        if (go) begin
            state_nx = LATENCY == 1 ? RESP : ACCESS;
            cnt_nx = '0;
        end else if (state == ACCESS) begin
            state_nx = cnt == CW'(LATENCY - 2) ? RESP : ACCESS;
            cnt_nx = cnt + 1'b1;
        end else if (state == RESP) begin
            state_nx = IDLE;
        end
        enter_resp = state != RESP && state_nx == RESP;
`ifdef DMEM_WRITE_ACK_EN
        ram_we = enter_resp && cur_store && !cur_fault;
`else
        ram_we = idle && mem_write_en && !cur_fault;
`endif
    end

    dmem_lane_align u_align (
        .lane       (cur_addr[1:0]),
        .load_type  (cur_lt),
        .store_type (cur_st),
        .word       (ram[idx]),
        .wdata      (cur_wdata),
        .load_data  (load_data),
        .store_data (store_data),
        .byte_en    (byte_en)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            data_out <= '0;
            addr_l <= '0;
            wdata_l <= '0;
            lt_l <= '0;
            st_l <= '0;
            store_l <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (go) begin
                addr_l <= ram_address;
                wdata_l <= data_in;
                lt_l <= load_type;
                st_l <= store_type;
                store_l <= mem_write_en;
            end
            if (enter_resp) data_out <= cur_store || cur_fault ? '0 : load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            for (int i = 0; i < 4; i++)
                if (byte_en[i]) ram[idx][8*i +: 8] <= store_data[8*i +: 8];
    end

    assign mem_busy = !idle;
    assign mem_valid = state == RESP;
    assign access_fault = mem_valid && cur_fault;
    assign unused_addr = ^cur_addr[31:AW+2];
endmodule
